// File: rtl/data_ram_sized.sv
// Byte-addressed data memory: byte/half/word access with sign or zero extension,
// misalignment detection and a word-at-a-time hardware clear sweep.
module data_ram_sized #(
    parameter int ADDR_W         = 8,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic        clr,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = ADDR_W - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               busy_q;
    logic [7:0]         mem_q [DEPTH];

    logic [ADDR_W-1:0]  byte_addr;
    logic [PTR_W-1:0]   word_addr;
    logic               unused_addr_bits;
    logic [7:0]         lane [4];
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_val;
    logic [3:0]         wr_be;
    logic [7:0]         wr_byte [4];
    logic               wr_en;

    // Upper address bits alias onto the array.
    assign byte_addr        = addr[ADDR_W-1:0];
    assign word_addr        = byte_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^addr[31:ADDR_W];

    assign misalign = (re | we) &
                      ((size == 2'b11) ||
                       (size == 2'b01 && byte_addr[0]) ||
                       (size == 2'b10 && byte_addr[1:0] != 2'b00));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane[k] = mem_q[{word_addr, k[1:0]}];
        end
    end

    always_comb begin
        rd_byte = lane[byte_addr[1:0]];
        rd_half = '0;
        rd_val  = '0;
        if (BIG_ENDIAN) begin
            rd_half = {lane[{byte_addr[1], 1'b0}], lane[{byte_addr[1], 1'b1}]};
        end else begin
            rd_half = {lane[{byte_addr[1], 1'b1}], lane[{byte_addr[1], 1'b0}]};
        end
        case (size)
            2'b00: rd_val = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
            2'b01: rd_val = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
            2'b10: rd_val = BIG_ENDIAN ? {lane[0], lane[1], lane[2], lane[3]}
                                       : {lane[3], lane[2], lane[1], lane[0]};
            default: rd_val = '0;
        endcase
    end

    assign rdata = (re && !busy_q && !misalign) ? rd_val : 32'd0;

    // Lane enables and data use the same byte ordering as the read path.
    always_comb begin
        wr_be = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_byte[k] = 8'd0;
        end
        case (size)
            2'b00: begin
                wr_be[byte_addr[1:0]]   = 1'b1;
                wr_byte[byte_addr[1:0]] = wdata[7:0];
            end
            2'b01: begin
                wr_be[{byte_addr[1], 1'b0}] = 1'b1;
                wr_be[{byte_addr[1], 1'b1}] = 1'b1;
                if (BIG_ENDIAN) begin
                    wr_byte[{byte_addr[1], 1'b0}] = wdata[15:8];
                    wr_byte[{byte_addr[1], 1'b1}] = wdata[7:0];
                end else begin
                    wr_byte[{byte_addr[1], 1'b0}] = wdata[7:0];
                    wr_byte[{byte_addr[1], 1'b1}] = wdata[15:8];
                end
            end
            2'b10: begin
                wr_be = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    wr_byte[k] = BIG_ENDIAN ? wdata[31-8*k -: 8] : wdata[8*k +: 8];
                end
            end
            default: wr_be = 4'b0000;
        endcase
    end

    // A clear request in IDLE takes priority over a same-cycle write.
    assign wr_en = we && !busy_q && !misalign && !RST && !clr;

    always_ff @(posedge CLK) begin
        if (!RST && state_q == CLEAR) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[{ptr_q, k[1:0]}] <= 8'd0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem_q[{word_addr, k[1:0]}] <= wr_byte[k];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            if (CLEAR_ON_RESET) begin
                state_q <= CLEAR;
                busy_q  <= 1'b1;
            end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_data_ram_sized.sv
// Scoreboard bench: big- and little-endian instances share stimulus; each
// expectation names which instance it applies to.
module tb_data_ram_sized;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic        sign_ext;
    logic        clr;
    logic [1:0]  size;

    logic [31:0] rd_be, rd_le;
    logic        mis_be, mis_le, busy_be, busy_le;

    data_ram_sized #(.ADDR_W(8), .BIG_ENDIAN(1'b1), .CLEAR_ON_RESET(1'b1)) dut_be (
        .CLK(clk), .RST(rst), .addr(addr), .re(re), .we(we), .size(size),
        .sign_ext(sign_ext), .wdata(wdata), .clr(clr),
        .rdata(rd_be), .misalign(mis_be), .busy(busy_be)
    );

    data_ram_sized #(.ADDR_W(8), .BIG_ENDIAN(1'b0), .CLEAR_ON_RESET(1'b1)) dut_le (
        .CLK(clk), .RST(rst), .addr(addr), .re(re), .we(we), .size(size),
        .sign_ext(sign_ext), .wdata(wdata), .clr(clr),
        .rdata(rd_le), .misalign(mis_le), .busy(busy_le)
    );

    // Expected entries are {busy, misalign, rdata}; sel 0 = big-endian DUT.
    logic [33:0] exp_q[$];
    bit          sel_q[$];
    string       name_q[$];
    logic        chk = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [33:0] mon_exp;
    logic [33:0] mon_act;
    bit          mon_sel;
    string       mon_name;

    always @(negedge clk) begin
        if (chk) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got an output with no expected entry");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_sel  = sel_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = mon_sel ? {busy_le, mis_le, rd_le} : {busy_be, mis_be, rd_be};
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: got busy=%b misalign=%b rdata=%08h, expected busy=%b misalign=%b rdata=%08h",
                             mon_name, mon_act[33], mon_act[32], mon_act[31:0],
                             mon_exp[33], mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic step(input bit sel, input logic r, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] ad, input logic [31:0] wd,
                        input logic c, input logic eb, input logic em,
                        input logic [31:0] erd, input string nm);
        re       = r;
        we       = w;
        size     = sz;
        sign_ext = sx;
        addr     = ad;
        wdata    = wd;
        clr      = c;
        exp_q.push_back({eb, em, erd});
        sel_q.push_back(sel);
        name_q.push_back(nm);
        chk = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; clr = 1'b0;
        tick();
        rst = 1'b0;

        // Reset clear: busy for exactly 64 cycles, reads return 0 meanwhile.
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 0, 2'b10, 0, 32'h00, 32'h0, 0, 1, 0, 32'h0, "reset_sweep_busy");
        end
        step(0, 1, 0, 2'b10, 0, 32'h00, 32'h0, 0, 0, 0, 32'h0, "clear_rd_00");
        step(0, 1, 0, 2'b10, 0, 32'h7C, 32'h0, 0, 0, 0, 32'h0, "clear_rd_7c");
        step(0, 1, 0, 2'b10, 0, 32'hFC, 32'h0, 0, 0, 0, 32'h0, "clear_rd_fc");

        // Word round trip and sub-word accesses on the big-endian instance.
        step(0, 0, 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 0, 0, 32'h0, "wr_word_10");
        step(0, 1, 0, 2'b00, 1, 32'h10, 32'h0, 0, 0, 0, 32'hFFFFFF88, "rd_byte_10_sx");
        step(0, 1, 0, 2'b00, 0, 32'h10, 32'h0, 0, 0, 0, 32'h00000088, "rd_byte_10_zx");
        step(0, 1, 0, 2'b01, 1, 32'h12, 32'h0, 0, 0, 0, 32'hFFFFAABB, "rd_half_12_sx");
        step(0, 1, 0, 2'b01, 0, 32'h10, 32'h0, 0, 0, 0, 32'h00008899, "rd_half_10_zx");
        step(0, 1, 0, 2'b10, 1, 32'h10, 32'h0, 0, 0, 0, 32'h8899AABB, "rd_word_sx_ignored");
        step(0, 0, 1, 2'b00, 0, 32'h13, 32'hFFFFFF5A, 0, 0, 0, 32'h0, "wr_byte_13");
        step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, 32'h8899AA5A, "rd_after_byte_wr");
        step(0, 0, 1, 2'b01, 0, 32'h10, 32'hFFFF1234, 0, 0, 0, 32'h0, "wr_half_10");
        step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, 32'h1234AA5A, "rd_after_half_wr");

        // Read during write returns the old data, new data on the next cycle.
        step(0, 1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 0, 0, 0, 32'h1234AA5A, "rdw_old");
        step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, 32'hCAFEF00D, "rdw_new");

        // Misalignment.
        step(0, 0, 1, 2'b10, 0, 32'h21, 32'hDEADBEEF, 0, 0, 1, 32'h0, "mis_wr_word_21");
        step(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, "mis_wr_dropped");
        step(0, 1, 0, 2'b01, 0, 32'h11, 32'h0, 0, 0, 1, 32'h0, "mis_rd_half_11");
        step(0, 1, 0, 2'b11, 0, 32'h00, 32'h0, 0, 0, 1, 32'h0, "mis_size_11");
        step(0, 0, 0, 2'b11, 0, 32'h03, 32'h0, 0, 0, 0, 32'h0, "mis_idle_zero");
        step(0, 1, 0, 2'b10, 0, 32'h12, 32'h0, 0, 0, 1, 32'h0, "mis_rd_word_12");

        // Clear request with a concurrent write, then reset mid-sweep.
        step(0, 0, 1, 2'b10, 0, 32'h40, 32'hFFFFFFFF, 1, 0, 0, 32'h0, "clr_with_we");
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 1, 0, 32'h0, "clr_sweep_busy");
        end
        rst = 1'b1;
        step(0, 0, 0, 2'b10, 0, 32'h00, 32'h0, 0, 1, 0, 32'h0, "rst_mid_sweep");
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            // clr mid-sweep must not restart; a write during busy must be dropped.
            step(0, 0, (i == 50), 2'b10, 0, 32'h00, 32'h12345678, (i == 10),
                 1, 0, 32'h0, "restart_sweep_busy");
        end
        step(0, 1, 0, 2'b10, 0, 32'h00, 32'h0, 0, 0, 0, 32'h0, "busy_wr_dropped");
        step(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 0, 0, 32'h0, "clr_we_dropped");
        step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, "sweep_cleared_10");

        // Aliasing and endianness.
        step(1, 0, 1, 2'b10, 0, 32'h104, 32'h11223344, 0, 0, 0, 32'h0, "le_wr_word_104");
        step(1, 1, 0, 2'b00, 0, 32'h04, 32'h0, 0, 0, 0, 32'h00000044, "le_rd_byte_04");
        step(1, 1, 0, 2'b10, 0, 32'h04, 32'h0, 0, 0, 0, 32'h11223344, "le_rd_word_04");
        step(1, 1, 0, 2'b01, 1, 32'h06, 32'h0, 0, 0, 0, 32'h00001122, "le_rd_half_06");
        step(1, 1, 0, 2'b00, 1, 32'hFF07, 32'h0, 0, 0, 0, 32'h00000011, "le_rd_byte_07_alias");
        step(0, 1, 0, 2'b00, 0, 32'h04, 32'h0, 0, 0, 0, 32'h00000011, "be_rd_byte_04");
        step(0, 1, 0, 2'b10, 0, 32'h204, 32'h0, 0, 0, 0, 32'h11223344, "be_rd_word_alias");
        step(0, 1, 0, 2'b01, 1, 32'h04, 32'h0, 0, 0, 0, 32'h00001122, "be_rd_half_04");

        re = 1'b0; we = 1'b0; clr = 1'b0;
        tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
